// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and holds the
// fetched word in IR until the control unit advances or redirects.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] NOP_INSTR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        advance,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [15:0] ir_pc,
    output logic [15:0] pc_next
);

    typedef enum logic [1:0] {StReq, StHold, StFlush} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic [15:0] pend_q, pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReq;
            pc_q       <= RESET_VECTOR;
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b0;
            ir_pc_q    <= 16'h0000;
            pend_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_q    <= ir_pc_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_d    = ir_pc_q;
        pend_d     = pend_q;
        unique case (state_q)
            StReq: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Request is outstanding; its address must not move, so park the target.
                        pend_d  = redirect_pc;
                        state_d = StFlush;
                    end
                end else if (imem_ack) begin
                    ir_d       = imem_data;
                    ir_pc_d    = pc_q;
                    pc_d       = pc_q + 16'd1;
                    ir_valid_d = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (redirect || advance) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end
                    ir_d       = NOP_INSTR;
                    ir_valid_d = 1'b0;
                    state_d    = StReq;
                end
            end
            StFlush: begin
                if (imem_ack) begin
                    pc_d    = redirect ? redirect_pc : pend_q;
                    state_d = StReq;
                end else if (redirect) begin
                    pend_d = redirect_pc;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // Request is suppressed combinationally while reset is held.
    assign imem_req  = rst_n && (state_q != StHold);
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign ir_pc     = ir_pc_q;
    assign pc_next   = ir_pc_q + 16'd1;

endmodule
